// File: rtl/chip8_fb_ctrl.sv
// chip8_fb_ctrl
//   Owns the 32 x 64-bit CHIP-8 frame memory and shares it between the CPU
//   command port (CLS, sprite-row DRAW with XOR and collision detect) and the
//   scanout line fetcher. Only one row is accessed per cycle. Line fetches take
//   priority over commands, but a DRAW read/write pair is never split.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_op            0 = CLS, 1 = DRAW_ROW
//   cmd_x/cmd_y       DRAW start column / row
//   cmd_data          sprite byte, bit 7 is the leftmost pixel
//   done              one-cycle pulse when a command completes
//   collision         result of the last DRAW (a lit pixel was cleared)
//   line_req/line_row scanout fetch request pulse and row
//   line_valid        one-cycle pulse when line_data is updated
//   line_data         fetched row, bit c = pixel column c
module chip8_fb_ctrl #(
    parameter int ROWS = 32,
    parameter int COLS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [$clog2(COLS)-1:0]  cmd_x,
    input  logic [$clog2(ROWS)-1:0]  cmd_y,
    input  logic [7:0]               cmd_data,
    output logic                     done,
    output logic                     collision,
    input  logic                     line_req,
    input  logic [$clog2(ROWS)-1:0]  line_row,
    output logic                     line_valid,
    output logic [COLS-1:0]          line_data
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {
        IDLE,
        DRAW_RD,
        DRAW_WR,
        CLS,
        FETCH
    } state_t;

    state_t          state, state_n;
    state_t          ret, ret_n;      // where FETCH resumes
    logic            pend;
    logic [RW-1:0]   pend_row;
    logic [RW-1:0]   cls_cnt;
    logic [CW-1:0]   draw_x;
    logic [RW-1:0]   draw_y;
    logic [7:0]      draw_data;
    logic [COLS-1:0] temp;
    logic [COLS-1:0] wr_row;
    logic            hit;
    logic            done_n;
    logic            accept;
    logic            fetch_want;
    logic [CW-1:0]   col;
    logic [COLS-1:0] mem [ROWS];

    assign cmd_ready  = (state == IDLE) && !pend && !line_req;
    assign fetch_want = pend || line_req;

    always_comb begin
        state_n = state;
        ret_n   = ret;
        done_n  = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_want) begin
                    state_n = FETCH;
                    ret_n   = IDLE;
                end else if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = cmd_op ? DRAW_RD : CLS;
                end
            end
            DRAW_RD: state_n = DRAW_WR;
            DRAW_WR: begin
                done_n  = 1'b1;
                ret_n   = IDLE;
                state_n = fetch_want ? FETCH : IDLE;
            end
            CLS: begin
                if (cls_cnt == RW'(ROWS - 1)) begin
                    done_n  = 1'b1;
                    ret_n   = IDLE;
                    state_n = fetch_want ? FETCH : IDLE;
                end else begin
                    ret_n   = CLS;
                    state_n = fetch_want ? FETCH : CLS;
                end
            end
            // a request arriving during FETCH re-arms pend, so fetch again
            FETCH:   state_n = line_req ? FETCH : ret;
            default: state_n = IDLE;
        endcase
    end

    // XOR merge of the sprite byte into the row read in DRAW_RD; columns wrap
    always_comb begin
        wr_row = temp;
        hit    = 1'b0;
        col    = '0;
        for (int i = 0; i < 8; i++) begin
            col         = draw_x + CW'(i);
            wr_row[col] = temp[col] ^ draw_data[7-i];
            hit         = hit | (temp[col] & draw_data[7-i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ret        <= IDLE;
            pend       <= 1'b0;
            cls_cnt    <= '0;
            done       <= 1'b0;
            collision  <= 1'b0;
            line_valid <= 1'b0;
            line_data  <= '0;
            for (int r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            done       <= done_n;
            line_valid <= (state == FETCH);

            if (line_req) begin
                pend <= 1'b1;
            end else if (state == FETCH) begin
                pend <= 1'b0;
            end

            if (accept && !cmd_op) begin
                cls_cnt <= '0;
            end else if (state == CLS) begin
                cls_cnt <= cls_cnt + RW'(1);
            end

            if (state == DRAW_WR) begin
                mem[draw_y] <= wr_row;
                collision   <= hit;
            end
            if (state == CLS) begin
                mem[cls_cnt] <= '0;
            end
            if (state == FETCH) begin
                line_data <= mem[pend_row];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_req) begin
            pend_row <= line_row;
        end
        if (accept) begin
            draw_x    <= cmd_x;
            draw_y    <= cmd_y;
            draw_data <= cmd_data;
        end
        if (state == DRAW_RD) begin
            temp <= mem[draw_y];
        end
    end

endmodule

// File: tb/tb_chip8_fb_ctrl.sv
// Directed testbench for chip8_fb_ctrl.
module tb_chip8_fb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [7:0]  cmd_data;
    logic        done;
    logic        collision;
    logic        line_req;
    logic [4:0]  line_row;
    logic        line_valid;
    logic [63:0] line_data;

    int n_vec = 0;
    int n_err = 0;

    chip8_fb_ctrl #(.ROWS(32), .COLS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_data   (cmd_data),
        .done       (done),
        .collision  (collision),
        .line_req   (line_req),
        .line_row   (line_row),
        .line_valid (line_valid),
        .line_data  (line_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic draw(input logic [5:0] x, input logic [4:0] y, input logic [7:0] d,
                        input logic exp_coll);
        int n;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_x = x; cmd_y = y; cmd_data = d;
        #1;
        chk("draw_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            step();
            n++;
        end
        chk("draw_done_lat", n, 3);
        chk("draw_coll", collision, exp_coll);
        step();
        chk("done_width", done, 0);
    endtask

    task automatic fetch(input logic [4:0] row, input logic [63:0] exp_data);
        int n;
        line_req = 1'b1; line_row = row;
        step();
        line_req = 1'b0;
        n = 1;
        while (!line_valid && n < 10) begin
            step();
            n++;
        end
        chk("fetch_lat", n, 2);
        chk("fetch_data", line_data, exp_data);
        step();
        chk("lv_width", line_valid, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_coll"}, collision, 0);
        chk({tag, "_lv"}, line_valid, 0);
        chk({tag, "_ldata"}, line_data, 64'd0);
    endtask

    initial begin
        logic [63:0] expq [$];
        logic [63:0] ld;
        int done_k, lv_k, nlv, n_done;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x = '0; cmd_y = '0;
        cmd_data = '0; line_req = 1'b0; line_row = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk_reset_outputs("rst0");

        fetch(5'd0, 64'd0);
        fetch(5'd31, 64'd0);

        // basic draw, repeat (collision), wrapping draw
        draw(6'd0, 5'd3, 8'hF0, 1'b0);
        fetch(5'd3, 64'h000000000000000F);
        draw(6'd0, 5'd3, 8'hF0, 1'b1);
        fetch(5'd3, 64'd0);
        draw(6'd62, 5'd3, 8'hC3, 1'b0);
        fetch(5'd3, 64'hC000000000000030);

        // line_req during DRAW_RD of a draw to the same row
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_x = 6'd0; cmd_y = 5'd3; cmd_data = 8'h0F;
        step();
        cmd_valid = 1'b0; line_req = 1'b1; line_row = 5'd3;
        step();
        line_req = 1'b0;
        done_k = 0; lv_k = 0; ld = '0;
        for (int c = 2; c < 9; c++) begin
            if (done && done_k == 0) done_k = c;
            if (line_valid && lv_k == 0) begin
                lv_k = c;
                ld = line_data;
            end
            step();
        end
        chk("rmw_done_cyc", done_k, 3);
        chk("rmw_lv_cyc", lv_k, 4);
        chk("rmw_ldata", ld, 64'hC0000000000000C0);
        chk("rmw_coll", collision, 1);

        // fetch and command in the same cycle: fetch wins
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_x = 6'd0; cmd_y = 5'd10; cmd_data = 8'hFF;
        line_req = 1'b1; line_row = 5'd3;
        #1;
        chk("tie_ready", cmd_ready, 0);
        step();
        cmd_valid = 1'b0; line_req = 1'b0;
        n_done = 0; lv_k = 0;
        for (int c = 1; c < 8; c++) begin
            if (done) n_done++;
            if (line_valid && lv_k == 0) lv_k = c;
            step();
        end
        chk("tie_no_done", n_done, 0);
        chk("tie_lv_cyc", lv_k, 2);
        fetch(5'd10, 64'd0);

        // CLS with fetches interleaved every 7 cycles
        draw(6'd0, 5'd0, 8'hFF, 1'b0);
        draw(6'd0, 5'd1, 8'hFF, 1'b0);
        draw(6'd8, 5'd31, 8'hA5, 1'b0);
        cmd_valid = 1'b1; cmd_op = 1'b0;
        step();
        cmd_valid = 1'b0;
        done_k = 0; nlv = 0;
        for (int k = 1; k < 60; k++) begin
            if (line_valid) begin
                nlv++;
                if (expq.size() > 0) chk("cls_line", line_data, expq.pop_front());
            end
            if (done) begin
                done_k = k;
                break;
            end
            line_req = 1'b0;
            if (k % 7 == 0 && k <= 28) begin
                line_req = 1'b1;
                case (k)
                    14:      begin line_row = 5'd0;  expq.push_back(64'd0); end
                    28:      begin line_row = 5'd1;  expq.push_back(64'd0); end
                    default: begin line_row = 5'd31; expq.push_back(64'h000000000000A500); end
                endcase
            end
            step();
        end
        line_req = 1'b0;
        chk("cls_done_cyc", done_k, 37);
        chk("cls_nfetch", nlv, 4);
        step();
        chk("cls_done_width", done, 0);
        fetch(5'd0, 64'd0);
        fetch(5'd1, 64'd0);
        fetch(5'd3, 64'd0);
        fetch(5'd31, 64'd0);

        // reset in the middle of CLS
        draw(6'd8, 5'd31, 8'hA5, 1'b0);
        draw(6'd8, 5'd31, 8'h80, 1'b1);
        fetch(5'd31, 64'h000000000000A400);
        cmd_valid = 1'b1; cmd_op = 1'b0;
        step();
        cmd_valid = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_cls");
        step();
        reset = 1'b0;
        step();
        fetch(5'd31, 64'd0);

        // reset in DRAW_WR
        draw(6'd0, 5'd31, 8'hFF, 1'b0);
        draw(6'd0, 5'd31, 8'h80, 1'b1);
        fetch(5'd31, 64'h00000000000000FE);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_x = 6'd0; cmd_y = 5'd31; cmd_data = 8'h01;
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_draw");
        step();
        reset = 1'b0;
        step();
        chk("rst_draw_nodone", done, 0);
        fetch(5'd31, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
